vdc_clk_ctrl: RTL and testbench
===============================

Name: vdc_clk_ctrl

Overview:
Sits directly downstream of the VDC 32 MHz PLL and consumes its output clock and lock flag.
- Qualifies PLL lock and holds the VDC core in reset until the clock has been stable.
- Generates the 8563 dot-clock enable (16 MHz, or 8 MHz when pixel-doubled) and a character-cell enable from the programmable character width.
- All VDC video logic runs on clk_vdc, gated by these enables.

Parameters:
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before the VDC leaves reset (must be ≥2).
SYNC_STAGES, 2, flop stages in the pll_locked synchronizer (must be ≥2).

Ports:
clk_vdc  in  1  32 MHz PLL output clock.
rst  in  1  Asynchronous, active-high reset.
pll_locked  in  1  PLL lock flag; asynchronous to clk_vdc.
pix_dbl  in  1  1 = dot clock divided by 4 (40-column/double mode); 0 = divided by 2.
char_width  in  4  Total character cell width minus 1, in pixels (0..15).
vdc_rst  out  1  Synchronous reset to the VDC core.
ready  out  1  High in RUN.
ce_pix  out  1  One-cycle dot-clock enable.
ce_char  out  1  One-cycle enable on the last pixel of each character cell.
lock_lost  out  1  Sticky flag: lock dropped while in RUN.

Behaviour:
Reset:
- Async rst clears synchronizer flops, state, counters and flags.
- Reset values: vdc_rst=1, ready=0, ce_pix=0, ce_char=0, lock_lost=0.
- All outputs are registered.

Lock synchronizer:
- pll_locked passes through SYNC_STAGES flops and produces lock_s.

State machine:
- WAIT_LOCK: vdc_rst=1, ready=0, stable counter=0. lock_s=1 -> SETTLE.
- SETTLE: stable counter increments every cycle. lock_s=0 -> WAIT_LOCK and counter cleared. Counter reaching LOCK_STABLE_CYCLES-1 with lock_s=1 -> RUN.
- RUN: vdc_rst=0, ready=1. lock_s=0 -> WAIT_LOCK: vdc_rst=1 and ready=0 on the next edge, lock_lost set.
- lock_lost clears only on rst.

Pixel divider (RUN only):
- 2-bit div_cnt; period P = 2, or 4 when pix_dbl_q=1.
- ce_pix=1 in the cycle where div_cnt==P-1; div_cnt then wraps to 0.
- pix_dbl_q loads pix_dbl on RUN entry and on each ce_pix. A change takes effect in the following pixel period, so no runt or stretched period occurs.

Character counter:
- 4-bit char_cnt increments on ce_pix.
- ce_char = ce_pix && char_cnt==char_width_q; char_cnt wraps to 0 on ce_char.
- char_width_q loads on RUN entry and on each ce_char, so mid-cell changes never truncate a cell.
- char_width=0 -> ce_char coincides with every ce_pix.

Timing:
- RUN entry: div_cnt, char_cnt cleared.
- First ce_pix arrives P cycles after vdc_rst first samples low.
- Outside RUN: ce_pix=ce_char=0 and counters held at 0.
- Lock drop in RUN: enables go 0 in the same cycle vdc_rst reasserts.

Optional Feature:
VDC_LOCK_LOSS_CNT_EN
- Defined: extra output lock_loss_cnt[7:0] counts RUN->WAIT_LOCK transitions. It saturates at 255 and is reset to 0 by rst.
- Undefined: the port and counter are absent; lock_lost alone reports loss.

Decomposition:
- Package vdc_clk_pkg: state enum (WAIT_LOCK, SETTLE, RUN), DIV_W=2, CHAR_W=4, and the divider period constants P_NORM=2, P_DBL=4.
- One sub-module: vdc_sync_bit, a parameterized SYNC_STAGES-flop async-input synchronizer with async active-high reset. It is instantiated for pll_locked.

Test Plan:
1. Power-up lock (LOCK_STABLE_CYCLES=16, SYNC_STAGES=2): pll_locked rises -> vdc_rst stays 1 for 2+16 cycles and then goes 0 with ready=1. First ce_pix follows 2 cycles later.
2. Glitchy lock: pll_locked high for 10 cycles, low for 3, then high -> SETTLE aborts and the counter restarts. vdc_rst falls only 18 cycles after the final rise; lock_lost stays 0.
3. Divider switch: in RUN with pix_dbl=0, ce_pix every 2 cycles. Set pix_dbl=1 mid-period -> the current period completes at 2 cycles, then ce_pix every 4. No ce_pix gap other than 4.
4. Character cell: char_width=7 -> ce_char every 8th ce_pix (16 cycles). Change to 9 mid-cell -> the current cell still ends at 8 pixels, the next cell is 10 pixels. char_width=0 -> ce_char==ce_pix.
5. Lock loss in RUN: drop pll_locked -> after 2 sync cycles, vdc_rst=1, ready=0, ce_pix=ce_char=0, lock_lost=1. Relock -> full SETTLE sequence; lock_lost remains 1 until rst.
6. Async reset mid-RUN: assert rst between edges -> all outputs take reset values immediately without a clock edge. Deassert with pll_locked high -> the sequence of scenario 1 repeats.

Source files
------------

// File: rtl/vdc_clk_pkg.sv
// vdc_clk_pkg: shared types and constants for the VDC clock controller.
//   state_t     : controller state (WAIT_LOCK, SETTLE, RUN)
//   DIV_W/CHAR_W: pixel divider and character counter widths
//   P_NORM/P_DBL: pixel divider periods (normal / pixel-doubled)
package vdc_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } state_t;

    localparam int DIV_W  = 2;
    localparam int CHAR_W = 4;
    localparam int P_NORM = 2;
    localparam int P_DBL  = 4;

    // Terminal divider count for the selected pixel period.
    function automatic logic [DIV_W-1:0] div_last(input logic dbl);
        return dbl ? DIV_W'(P_DBL - 1) : DIV_W'(P_NORM - 1);
    endfunction

endpackage

// File: rtl/vdc_sync_bit.sv
// vdc_sync_bit: multi-flop synchronizer for a single asynchronous input.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears all stages
//   d   : asynchronous input
//   q   : synchronized output (last stage)
module vdc_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= '0;
        else     ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/vdc_clk_ctrl.sv
// vdc_clk_ctrl: PLL lock qualification and 8563 dot/character clock enables.
//   clk_vdc       : 32 MHz PLL output clock
//   rst           : asynchronous active-high reset
//   pll_locked    : PLL lock flag, asynchronous to clk_vdc
//   pix_dbl       : 1 = dot clock /4, 0 = dot clock /2
//   char_width    : character cell width minus 1, in pixels
//   vdc_rst       : synchronous reset to the VDC core (high until RUN)
//   ready         : high in RUN
//   ce_pix        : one-cycle dot-clock enable
//   ce_char       : one-cycle enable on the last pixel of each cell
//   lock_lost     : sticky, lock dropped while in RUN
//   lock_loss_cnt : saturating count of RUN->WAIT_LOCK transitions
//                   (present only when VDC_LOCK_LOSS_CNT_EN is defined)
module vdc_clk_ctrl
    import vdc_clk_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES        = 2
) (
    input  logic              clk_vdc,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              pix_dbl,
    input  logic [CHAR_W-1:0] char_width,
    output logic              vdc_rst,
    output logic              ready,
    output logic              ce_pix,
    output logic              ce_char,
    output logic              lock_lost
`ifdef VDC_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0]        lock_loss_cnt
`endif
);

    localparam int              CNT_W    = $clog2(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  stable_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [CHAR_W-1:0] char_cnt;
    logic [CHAR_W-1:0] char_width_q;
    logic              pix_dbl_q;
    logic              lock_s;
    logic              pix_wrap;
    logic              char_wrap;

    vdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clk_vdc),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // Period and cell length come from the latched copies, so input changes
    // only take effect at the next period/cell boundary.
    assign pix_wrap  = (div_cnt == div_last(pix_dbl_q));
    assign char_wrap = (char_cnt == char_width_q);

    always_ff @(posedge clk_vdc or posedge rst) begin
        if (rst) begin
            state        <= WAIT_LOCK;
            stable_cnt   <= '0;
            div_cnt      <= '0;
            char_cnt     <= '0;
            char_width_q <= '0;
            pix_dbl_q    <= 1'b0;
            vdc_rst      <= 1'b1;
            ready        <= 1'b0;
            ce_pix       <= 1'b0;
            ce_char      <= 1'b0;
            lock_lost    <= 1'b0;
`ifdef VDC_LOCK_LOSS_CNT_EN
            lock_loss_cnt <= '0;
`endif
        end else begin
            ce_pix  <= 1'b0;
            ce_char <= 1'b0;
            case (state)
                WAIT_LOCK: begin
                    stable_cnt <= '0;
                    div_cnt    <= '0;
                    char_cnt   <= '0;
                    if (lock_s) state <= SETTLE;
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state      <= WAIT_LOCK;
                        stable_cnt <= '0;
                    end else if (stable_cnt == CNT_LAST) begin
                        state        <= RUN;
                        stable_cnt   <= '0;
                        vdc_rst      <= 1'b0;
                        ready        <= 1'b1;
                        div_cnt      <= '0;
                        char_cnt     <= '0;
                        pix_dbl_q    <= pix_dbl;
                        char_width_q <= char_width;
                    end else begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        // Enables stay at their 0 default this edge, so they
                        // drop together with vdc_rst reasserting.
                        state     <= WAIT_LOCK;
                        vdc_rst   <= 1'b1;
                        ready     <= 1'b0;
                        lock_lost <= 1'b1;
                        div_cnt   <= '0;
                        char_cnt  <= '0;
`ifdef VDC_LOCK_LOSS_CNT_EN
                        if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 1'b1;
`endif
                    end else if (pix_wrap) begin
                        div_cnt   <= '0;
                        ce_pix    <= 1'b1;
                        pix_dbl_q <= pix_dbl;
                        if (char_wrap) begin
                            char_cnt     <= '0;
                            ce_char      <= 1'b1;
                            char_width_q <= char_width;
                        end else begin
                            char_cnt <= char_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

endmodule

// File: tb/tb_vdc_clk_ctrl.sv
// tb_vdc_clk_ctrl: directed, table-driven bench for vdc_clk_ctrl with
// LOCK_STABLE_CYCLES=16 and SYNC_STAGES=2. Table rows apply inputs, run a
// number of cycles and compare the registered outputs; hand sequences cover
// divider switching, cell-width changes, lock loss and async reset.
module tb_vdc_clk_ctrl;

    localparam int LSC = 16;
    localparam int SS  = 2;

    logic       clk_vdc = 1'b0;
    logic       rst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pix_dbl = 1'b0;
    logic [3:0] char_width = 4'd7;
    logic       vdc_rst, ready, ce_pix, ce_char, lock_lost;
`ifdef VDC_LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    vdc_clk_ctrl #(.LOCK_STABLE_CYCLES(LSC), .SYNC_STAGES(SS)) dut (
        .clk_vdc    (clk_vdc),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pix_dbl    (pix_dbl),
        .char_width (char_width),
        .vdc_rst    (vdc_rst),
        .ready      (ready),
        .ce_pix     (ce_pix),
        .ce_char    (ce_char),
        .lock_lost  (lock_lost)
`ifdef VDC_LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #5 clk_vdc = ~clk_vdc;

    typedef struct {
        logic       lk;
        logic       pd;
        logic [3:0] cw;
        int         n;
        logic       e_rst;
        logic       e_rdy;
        logic       e_pix;
        logic       e_char;
        logic       e_lost;
    } vec_t;

    vec_t tbl[15];

    int total = 0;
    int bad   = 0;
    int gap = 0, cell_pix = 0, cc_mis = 0;
    int gap_q[$];
    int cell_q[$];
    int exp_gap[3]  = '{2, 4, 4};
    int exp_cell[7] = '{8, 8, 10, 1, 1, 1, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one cycle, sample 1 time unit after the edge, collect stats.
    task automatic tick();
        @(posedge clk_vdc);
        #1;
        gap++;
        if (ce_pix === 1'b1) begin
            gap_q.push_back(gap);
            gap = 0;
            cell_pix++;
        end
        if (ce_char === 1'b1) begin
            cell_q.push_back(cell_pix);
            cell_pix = 0;
        end
        if (ce_char !== ce_pix) cc_mis++;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            pll_locked = tbl[i].lk;
            pix_dbl    = tbl[i].pd;
            char_width = tbl[i].cw;
            tick_n(tbl[i].n);
            chk($sformatf("row%0d vdc_rst", i),   vdc_rst,   tbl[i].e_rst);
            chk($sformatf("row%0d ready", i),     ready,     tbl[i].e_rdy);
            chk($sformatf("row%0d ce_pix", i),    ce_pix,    tbl[i].e_pix);
            chk($sformatf("row%0d ce_char", i),   ce_char,   tbl[i].e_char);
            chk($sformatf("row%0d lock_lost", i), lock_lost, tbl[i].e_lost);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " vdc_rst"},   vdc_rst,   1);
        chk({tag, " ready"},     ready,     0);
        chk({tag, " ce_pix"},    ce_pix,    0);
        chk({tag, " ce_char"},   ce_char,   0);
        chk({tag, " lock_lost"}, lock_lost, 0);
`ifdef VDC_LOCK_LOSS_CNT_EN
        chk({tag, " lock_loss_cnt"}, lock_loss_cnt, 0);
`endif
    endtask

    initial begin
        logic seen;
        //           lk    pd    cw    n   rst   rdy   pix   chr   lost
        tbl[0]  = '{1'b0, 1'b0, 4'd7,  3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // idle, no lock
        tbl[1]  = '{1'b1, 1'b0, 4'd7, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // short lock
        tbl[2]  = '{1'b0, 1'b0, 4'd7,  3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // glitch low
        tbl[3]  = '{1'b1, 1'b0, 4'd7, 18, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // 2 sync + 16 settle
        tbl[4]  = '{1'b1, 1'b0, 4'd7,  1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // RUN entry
        tbl[5]  = '{1'b1, 1'b0, 4'd7,  1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 4'd7,  1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // first ce_pix
        tbl[7]  = '{1'b1, 1'b0, 4'd7,  1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 4'd7,  1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 4'd7, 18, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // relock, sticky
        tbl[10] = '{1'b1, 1'b0, 4'd7,  1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 4'd7,  2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 4'd7, 18, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // after async rst
        tbl[13] = '{1'b1, 1'b0, 4'd7,  1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 4'd7,  2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state
        #1 rst = 1'b1;
        #1 chk_reset_vals("por");
        tick_n(2);
        rst = 1'b0;

        // Glitchy lock, then power-up to RUN and first enables
        apply(0, 8);

        // Divider switch mid-period: 2, then 4, 4
        gap = 0;
        gap_q.delete();
        tick();
        pix_dbl = 1'b1;
        tick_n(12);
        chk("div gap count", gap_q.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < gap_q.size()) chk($sformatf("div gap%0d", i), gap_q[i], exp_gap[i]);
        pix_dbl = 1'b0;

        // Character cells: 8, change to 9 mid-cell -> 8 then 10, then width 0
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            tick();
            if (ce_char === 1'b1) seen = 1'b1;
        end
        chk("ce_char seen", seen, 1);
        cell_pix = 0;
        cell_q.delete();
        tick_n(16);
        tick_n(6);
        char_width = 4'd9;
        tick_n(10);
        tick_n(4);
        char_width = 4'd0;
        tick_n(16);
        cc_mis = 0;
        tick_n(8);
        chk("cw0 ce_char==ce_pix", cc_mis, 0);
        chk("cell count", cell_q.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < cell_q.size()) chk($sformatf("cell%0d pixels", i), cell_q[i], exp_cell[i]);

        // Lock loss in RUN, timed so ce_pix/ce_char would otherwise fire
        tick();
        pll_locked = 1'b0;
        char_width = 4'd7;
        tick_n(2);
        chk("loss sync vdc_rst", vdc_rst, 0);
        chk("loss sync ready", ready, 1);
        chk("loss sync lock_lost", lock_lost, 0);
        tick();
        chk("loss vdc_rst", vdc_rst, 1);
        chk("loss ready", ready, 0);
        chk("loss ce_pix", ce_pix, 0);
        chk("loss ce_char", ce_char, 0);
        chk("loss lock_lost", lock_lost, 1);
`ifdef VDC_LOCK_LOSS_CNT_EN
        chk("loss lock_loss_cnt", lock_loss_cnt, 1);
`endif
        tick_n(3);
        chk("wait vdc_rst", vdc_rst, 1);
        chk("wait lock_lost", lock_lost, 1);
        apply(9, 11);

        // Async reset between edges, then repeat power-up with lock held
        #2 rst = 1'b1;
        #1 chk_reset_vals("async");
        tick_n(2);
        chk("rst held vdc_rst", vdc_rst, 1);
        rst = 1'b0;
        apply(12, 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
